// File: rtl/imager_gen.sv
// Synthetic image-sensor model: programmable frame/line timing with porches,
// multi-lane test patterns, snapshot triggering and an exported frame counter.
module imager_gen #(
    parameter int DATA_WIDTH     = 10,
    parameter int NUM_ROWS_WIDTH = 12,
    parameter int NUM_COLS_WIDTH = 12,
    parameter int LANES          = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [2:0]                  mode,
    input  logic                        trigger_mode,
    input  logic                        trigger,
    input  logic [NUM_ROWS_WIDTH-1:0]   num_active_rows,
    input  logic [NUM_ROWS_WIDTH-1:0]   num_virtual_rows,
    input  logic [NUM_ROWS_WIDTH-1:0]   vblank_fp,
    input  logic [NUM_COLS_WIDTH-1:0]   num_active_cols,
    input  logic [NUM_COLS_WIDTH-1:0]   num_virtual_cols,
    input  logic [NUM_COLS_WIDTH-1:0]   hblank_fp,
    input  logic [31:0]                 noise_seed,
    output logic [LANES*DATA_WIDTH-1:0] dat,
    output logic                        fv,
    output logic                        lv,
    output logic [15:0]                 frame_count,
    output logic                        busy
);
    localparam int RW = NUM_ROWS_WIDTH + 1;
    localparam int CW = NUM_COLS_WIDTH + 1;
    localparam int XW = CW + 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_TRIG = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [RW-1:0]               row_q, row_d;
    logic [CW-1:0]               col_q, col_d;
    logic                        pending_q, pending_d;
    logic [15:0]                 frame_count_q, frame_count_d;
    logic [31:0]                 lfsr_q, lfsr_d;
    logic [LANES*DATA_WIDTH-1:0] dat_q, dat_d;
    logic                        fv_q, fv_d, lv_q, lv_d, busy_q, busy_d;

    logic [RW-1:0] total_rows_s, last_row_s, fv_end_s, y_s;
    logic [CW-1:0] total_cols_s, last_col_s, lv_end_s, b_s;
    logic [XW-1:0] x_s;
    logic [31:0]   step_s;
    logic          fv_wire_s, lv_wire_s, row_end_s, col_end_s, trig_req_s;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pixel(
        input logic [2:0]    m,
        input logic [XW-1:0] x,
        input logic [RW-1:0] y,
        input logic [15:0]   fc,
        input logic [31:0]   noise
    );
        logic [DATA_WIDTH-1:0] p;
        case (m)
            3'd0:    p = DATA_WIDTH'(noise);
            3'd1:    p = DATA_WIDTH'(x);
            3'd2:    p = DATA_WIDTH'(y);
            3'd3:    p = DATA_WIDTH'(x) + DATA_WIDTH'(y);
            3'd4:    p = DATA_WIDTH'(fc);
            3'd5:    p = DATA_WIDTH'(fc) + DATA_WIDTH'(x) + DATA_WIDTH'(y);
            3'd6:    p = DATA_WIDTH'({1'b0, y[0], x[0]} + 3'd1) << (DATA_WIDTH - 3);
            3'd7:    p = (x[3] ^ y[3]) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
            default: p = {DATA_WIDTH{1'b0}};
        endcase
        return p;
    endfunction

    // Timing windows, per-lane pixel generation and noise LFSR advance
    always_comb begin
        total_rows_s = {1'b0, num_active_rows} + {1'b0, num_virtual_rows};
        total_cols_s = {1'b0, num_active_cols} + {1'b0, num_virtual_cols};
        last_row_s   = (total_rows_s == {RW{1'b0}}) ? {RW{1'b0}} : total_rows_s - RW'(1'b1);
        last_col_s   = (total_cols_s == {CW{1'b0}}) ? {CW{1'b0}} : total_cols_s - CW'(1'b1);
        // >= rather than == so a mid-frame shrink of the totals still wraps
        row_end_s    = (row_q >= last_row_s);
        col_end_s    = (col_q >= last_col_s);
        fv_end_s     = {1'b0, vblank_fp} + {1'b0, num_active_rows};
        lv_end_s     = {1'b0, hblank_fp} + {1'b0, num_active_cols};
        fv_wire_s    = (state_q == ST_RUN) && (row_q >= {1'b0, vblank_fp}) && (row_q < fv_end_s);
        lv_wire_s    = fv_wire_s && (col_q >= {1'b0, hblank_fp}) && (col_q < lv_end_s);
        y_s          = row_q - {1'b0, vblank_fp};
        b_s          = col_q - {1'b0, hblank_fp};

        step_s = lfsr_q;
        x_s    = {XW{1'b0}};
        dat_d  = {(LANES*DATA_WIDTH){1'b0}};
        for (int k = 0; k < LANES; k++) begin
            step_s = lfsr_step(step_s);
            x_s    = XW'(b_s) * XW'(LANES) + XW'(k);
            if (lv_wire_s && enable) begin
                dat_d[k*DATA_WIDTH +: DATA_WIDTH] = pixel(mode, x_s, y_s, frame_count_q, step_s);
            end else begin
                dat_d[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end
        end
        fv_d = enable && fv_wire_s;
        lv_d = enable && lv_wire_s;

        if (!fv_wire_s && (noise_seed != 32'd0)) begin
            lfsr_d = noise_seed;
        end else if (lv_wire_s) begin
            lfsr_d = step_s;
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Frame sequencing: counters, trigger handling and frame counting
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        pending_d     = pending_q;
        frame_count_d = frame_count_q;
        trig_req_s    = trigger && trigger_mode;
        if (!enable) begin
            state_d   = ST_IDLE;
            row_d     = {RW{1'b0}};
            col_d     = {CW{1'b0}};
            pending_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = trigger_mode ? ST_WAIT_TRIG : ST_RUN;
                end
                ST_RUN: begin
                    pending_d = pending_q || trig_req_s;
                    if (col_end_s) begin
                        col_d = {CW{1'b0}};
                        if (row_end_s) begin
                            row_d         = {RW{1'b0}};
                            frame_count_d = frame_count_q + 16'd1;
                            // A trigger landing on the very last beat also chains the next frame
                            if (pending_q || trig_req_s) begin
                                pending_d = 1'b0;
                                state_d   = ST_RUN;
                            end else if (trigger_mode) begin
                                state_d = ST_WAIT_TRIG;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end else begin
                            row_d = row_q + RW'(1'b1);
                        end
                    end else begin
                        col_d = col_q + CW'(1'b1);
                    end
                end
                ST_WAIT_TRIG: begin
                    row_d     = {RW{1'b0}};
                    col_d     = {CW{1'b0}};
                    pending_d = 1'b0;
                    state_d   = (trigger || !trigger_mode) ? ST_RUN : ST_WAIT_TRIG;
                end
                default: begin
                    state_d   = ST_IDLE;
                    row_d     = {RW{1'b0}};
                    col_d     = {CW{1'b0}};
                    pending_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d == ST_RUN);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            row_q         <= {RW{1'b0}};
            col_q         <= {CW{1'b0}};
            pending_q     <= 1'b0;
            frame_count_q <= 16'd0;
            lfsr_q        <= 32'd1;
            dat_q         <= {(LANES*DATA_WIDTH){1'b0}};
            fv_q          <= 1'b0;
            lv_q          <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            pending_q     <= pending_d;
            frame_count_q <= frame_count_d;
            lfsr_q        <= lfsr_d;
            dat_q         <= dat_d;
            fv_q          <= fv_d;
            lv_q          <= lv_d;
            busy_q        <= busy_d;
        end
    end

    assign dat         = dat_q;
    assign fv          = fv_q;
    assign lv          = lv_q;
    assign frame_count = frame_count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_imager_gen.sv
// Self-checking bench for imager_gen: table of frame configurations checked
// through a per-cycle scoreboard, plus trigger, enable and reset sequences.
module tb_imager_gen;
    localparam int DW  = 10;
    localparam int RWI = 12;
    localparam int CWI = 12;
    localparam int LN  = 2;

    logic              clk = 1'b0;
    logic              reset_n, enable, trigger_mode, trigger;
    logic [2:0]        mode;
    logic [RWI-1:0]    num_active_rows, num_virtual_rows, vblank_fp;
    logic [CWI-1:0]    num_active_cols, num_virtual_cols, hblank_fp;
    logic [31:0]       noise_seed;
    logic [LN*DW-1:0]  dat;
    logic              fv, lv, busy;
    logic [15:0]       frame_count;

    always #5 clk = ~clk;

    imager_gen #(
        .DATA_WIDTH(DW), .NUM_ROWS_WIDTH(RWI), .NUM_COLS_WIDTH(CWI), .LANES(LN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .trigger_mode(trigger_mode), .trigger(trigger),
        .num_active_rows(num_active_rows), .num_virtual_rows(num_virtual_rows),
        .vblank_fp(vblank_fp), .num_active_cols(num_active_cols),
        .num_virtual_cols(num_virtual_cols), .hblank_fp(hblank_fp),
        .noise_seed(noise_seed), .dat(dat), .fv(fv), .lv(lv),
        .frame_count(frame_count), .busy(busy)
    );

    typedef struct {
        logic            fv;
        logic            lv;
        logic [LN*DW-1:0] dat;
        logic [15:0]     fc;
        logic            busy;
    } exp_t;

    typedef struct {
        logic [2:0]  mode;
        int          ar, vr, vfp, ac, vc, hfp;
        logic [31:0] seed;
        int          period;
    } vec_t;

    exp_t        q[$];
    vec_t        tbl[10];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_lfsr = 32'd1;
    int          m_fc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] s);
        return {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
    endfunction

    function automatic logic [DW-1:0] pix(input logic [2:0] m, input int x, input int y,
                                          input int fc, input logic [31:0] n);
        int idx;
        idx = (y % 2) * 2 + (x % 2);
        case (m)
            3'd0:    return n[DW-1:0];
            3'd1:    return DW'(x);
            3'd2:    return DW'(y);
            3'd3:    return DW'(x + y);
            3'd4:    return DW'(fc);
            3'd5:    return DW'(fc + x + y);
            3'd6:    return DW'((idx + 1) * (1 << (DW - 3)));
            3'd7:    return (((x / 8) % 2) != ((y / 8) % 2)) ? {DW{1'b1}} : {DW{1'b0}};
            default: return {DW{1'b0}};
        endcase
    endfunction

    // Push one full frame of expected per-cycle outputs
    task automatic predict(input vec_t v, input logic busy_last);
        int tr, tc, r, c, x, y;
        logic f, l;
        exp_t e;
        tr = v.ar + v.vr;
        tc = v.ac + v.vc;
        if (tr == 0) tr = 1;
        if (tc == 0) tc = 1;
        for (int i = 0; i < v.period; i++) begin
            r = i / tc;
            c = i % tc;
            f = (r >= v.vfp) && (r < v.vfp + v.ar);
            l = f && (c >= v.hfp) && (c < v.hfp + v.ac);
            if (!f && v.seed != 32'd0) m_lfsr = v.seed;
            e.dat = '0;
            if (l) begin
                for (int k = 0; k < LN; k++) begin
                    m_lfsr = nxt(m_lfsr);
                    x = (c - v.hfp) * LN + k;
                    y = r - v.vfp;
                    e.dat[k*DW +: DW] = pix(v.mode, x, y, m_fc, m_lfsr);
                end
            end
            e.fv   = f;
            e.lv   = l;
            e.fc   = (i == v.period - 1) ? 16'(m_fc + 1) : 16'(m_fc);
            e.busy = (i == v.period - 1) ? busy_last : 1'b1;
            q.push_back(e);
        end
        m_fc++;
    endtask

    // Advance n cycles comparing DUT outputs against the scoreboard
    task automatic consume(input int n, input int trig_at);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (i == trig_at) trigger = 1'b1;
            @(posedge clk);
            #1;
            trigger = 1'b0;
            if (q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
                return;
            end
            e = q.pop_front();
            chk("fv", fv, e.fv);
            chk("lv", lv, e.lv);
            chk("dat", dat, e.dat);
            chk("frame_count", frame_count, e.fc);
            chk("busy", busy, e.busy);
        end
    endtask

    task automatic apply_cfg(input vec_t v);
        mode             = v.mode;
        num_active_rows  = RWI'(v.ar);
        num_virtual_rows = RWI'(v.vr);
        vblank_fp        = RWI'(v.vfp);
        num_active_cols  = CWI'(v.ac);
        num_virtual_cols = CWI'(v.vc);
        hblank_fp        = CWI'(v.hfp);
        noise_seed       = v.seed;
        if (v.seed != 32'd0) m_lfsr = v.seed;
    endtask

    task automatic run_entry(input vec_t v);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_fv", fv, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_fc", frame_count, 16'(m_fc));
        apply_cfg(v);
        enable = 1'b1;
        @(posedge clk);
        #1;
        predict(v, 1'b1);
        predict(v, 1'b1);
        consume(2 * v.period, -1);
    endtask

    initial begin
        //          mode  ar vr vfp ac vc hfp seed          period
        tbl[0] = '{3'd0, 4, 2, 1, 4, 2, 1, 32'h0000_0000, 36};
        tbl[1] = '{3'd0, 4, 2, 1, 4, 2, 1, 32'h0000_1234, 36};
        tbl[2] = '{3'd1, 4, 2, 1, 4, 2, 1, 32'h0000_0000, 36};
        tbl[3] = '{3'd6, 4, 2, 1, 4, 2, 1, 32'h0000_0000, 36};
        tbl[4] = '{3'd3, 3, 1, 0, 2, 3, 2, 32'h0000_0000, 20};
        tbl[5] = '{3'd7, 20, 1, 1, 6, 1, 0, 32'h0000_0000, 147};
        tbl[6] = '{3'd5, 2, 2, 2, 3, 1, 1, 32'h0000_0000, 16};
        tbl[7] = '{3'd4, 1, 1, 0, 1, 1, 1, 32'h0000_0000, 4};
        tbl[8] = '{3'd2, 2, 1, 1, 0, 3, 1, 32'h0000_0000, 9};
        tbl[9] = '{3'd1, 2, 0, 0, 0, 0, 0, 32'h0000_0000, 2};

        reset_n = 1'b0;
        enable = 1'b0;
        trigger_mode = 1'b0;
        trigger = 1'b0;
        apply_cfg(tbl[0]);
        #1;
        chk("rst_fv", fv, 1'b0);
        chk("rst_lv", lv, 1'b0);
        chk("rst_dat", dat, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fc", frame_count, 16'd0);
        #20;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_fv", fv, 1'b0);
        chk("post_rst_busy", busy, 1'b0);

        for (int i = 0; i < 10; i++) run_entry(tbl[i]);

        // Snapshot mode: nothing before a trigger, one frame per trigger
        enable = 1'b0;
        @(posedge clk);
        #1;
        apply_cfg(tbl[2]);
        trigger_mode = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("wait_fv", fv, 1'b0);
            chk("wait_busy", busy, 1'b0);
        end
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        predict(tbl[2], 1'b0);
        consume(36, -1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("after_snap_fv", fv, 1'b0);
            chk("after_snap_busy", busy, 1'b0);
            chk("after_snap_fc", frame_count, 16'(m_fc));
        end
        // Second trigger mid-frame chains the next frame with no gap
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        predict(tbl[2], 1'b1);
        predict(tbl[2], 1'b0);
        consume(72, 10);
        @(posedge clk);
        #1;
        chk("b2b_end_fv", fv, 1'b0);
        chk("b2b_end_busy", busy, 1'b0);

        // Enable drop mid-line, then restart from row 0 / col 0
        enable = 1'b0;
        @(posedge clk);
        #1;
        trigger_mode = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        #1;
        predict(tbl[2], 1'b1);
        consume(15, -1);
        q.delete();
        m_fc--;
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("dis_fv", fv, 1'b0);
        chk("dis_lv", lv, 1'b0);
        chk("dis_dat", dat, '0);
        chk("dis_busy", busy, 1'b0);
        chk("dis_fc", frame_count, 16'(m_fc));
        enable = 1'b1;
        @(posedge clk);
        #1;
        predict(tbl[2], 1'b1);
        consume(36, -1);

        // Asynchronous reset mid-line clears outputs without a clock edge
        predict(tbl[2], 1'b1);
        consume(20, -1);
        q.delete();
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_fv", fv, 1'b0);
        chk("async_rst_lv", lv, 1'b0);
        chk("async_rst_dat", dat, '0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_fc", frame_count, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imager_gen.md
Name: imager_gen

Overview:
- Synthetic image-sensor model for simulation benches; successor to the single-lane test imager.
- Adds multi-pixel-per-clock output, programmable horizontal/vertical front porches, an external-trigger (snapshot) mode, Bayer and checkerboard patterns, and an exported frame counter.
- Drives downstream capture/ISP blocks with fv/lv/dat timing identical in polarity to the existing imager.

Parameters:
DATA_WIDTH, 10, bits per pixel
NUM_ROWS_WIDTH, 12, width of row-count configuration inputs
NUM_COLS_WIDTH, 12, width of column (beat) configuration inputs
LANES, 2, pixels emitted per clock (1..8)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  run when high; low forces IDLE
mode  in  3  pattern select, see Behaviour
trigger_mode  in  1  0 free-run, 1 one frame per trigger
trigger  in  1  single-cycle frame request (trigger_mode=1)
num_active_rows  in  NUM_ROWS_WIDTH  active rows
num_virtual_rows  in  NUM_ROWS_WIDTH  blank rows per frame
vblank_fp  in  NUM_ROWS_WIDTH  blank rows before active (<= num_virtual_rows)
num_active_cols  in  NUM_COLS_WIDTH  active beats per row (pixels = beats*LANES)
num_virtual_cols  in  NUM_COLS_WIDTH  blank beats per row
hblank_fp  in  NUM_COLS_WIDTH  blank beats before active (<= num_virtual_cols)
noise_seed  in  32  LFSR reseed value; 0 = no reseed
dat  out  LANES*DATA_WIDTH  pixels, lane 0 in LSBs (lowest x)
fv  out  1  frame valid
lv  out  1  line valid
frame_count  out  16  completed-frame count
busy  out  1  high in RUN

Behaviour:
- Reset: dat=0, fv=0, lv=0, busy=0, frame_count=0, row/col counters=0, LFSR=1, pending=0, state=IDLE.
- Counters: col_count counts beats 0..total_cols-1, with total_cols=active+virtual at NUM_COLS_WIDTH+1 bits. Row count is analogous. A total of 0 is treated as 1.
- fv_wire = row_count in [vblank_fp, vblank_fp+num_active_rows).
- lv_wire = fv_wire && col_count in [hblank_fp, hblank_fp+num_active_cols).
- Active coordinates: y = row_count - vblank_fp; beat b = col_count - hblank_fp; lane k pixel x = b*LANES + k.
- Outputs registered: fv, lv, dat reflect the counter state one cycle earlier. dat=0 whenever lv_wire=0.
- Patterns per lane. All results are truncated to DATA_WIDTH.
  - 0: LFSR noise.
  - 1: x.
  - 2: y.
  - 3: x+y.
  - 4: frame_count.
  - 5: frame_count+x+y.
  - 6: Bayer. c={y[0],x[0]}, value=(c+1)<<(DATA_WIDTH-3).
  - 7: checkerboard. x[3]^y[3] ? all ones : 0.
- LFSR: 32-bit, next = {s[30:0], ~(s[31]^s[21]^s[1]^s[0])}.
  - Each lv_wire beat advances LANES steps; lane k uses the state after k+1 steps.
  - While fv_wire=0 and noise_seed!=0, LFSR loads noise_seed. With seed 0, the sequence continues across frames.
- FSM states IDLE, RUN, WAIT_TRIG:
  - IDLE: enable=1 and trigger_mode=0 -> RUN; enable=1 and trigger_mode=1 -> WAIT_TRIG.
  - RUN: counters advance each cycle. On the last beat of the last row: counters wrap to 0 and frame_count increments (wraps at 16 bits).
    - If trigger_mode=1 and pending=0 -> WAIT_TRIG.
    - If pending=1 -> stay in RUN and clear pending.
  - WAIT_TRIG: counters held at 0, fv/lv/dat=0. trigger=1 -> RUN next cycle.
  - Trigger during RUN sets pending (one-deep; further triggers are dropped). Trigger while trigger_mode=0 is ignored.
  - Switching trigger_mode 0->1 mid-frame: the current frame completes, then WAIT_TRIG. Switching 1->0 in WAIT_TRIG -> RUN.
  - enable=0 in any state: next cycle state=IDLE, counters=0, fv/lv/dat=0, pending=0. frame_count retained; the partial frame is not counted.
- Configuration inputs are sampled continuously. Changes mid-frame are legal but only defined at frame boundaries.
- busy = (state==RUN), registered.

Test Plan:
- LANES=2, mode=1, rows 4/2, cols 4/2, fps 1/1, free-run:
  - fv high rows 1..4, lv 4 beats per row.
  - dat lanes {1,0},{3,2},{5,4},{7,6}.
  - Frame period 36 clocks; frame_count increments every 36.
- mode=6, LANES=2, DATA_WIDTH=10: row y=0 lanes give 128,256; row y=1 lanes give 384,512.
- trigger_mode=1: no fv until trigger.
  - Trigger gives exactly one frame, then returns to WAIT_TRIG with busy=0.
  - A second trigger mid-frame starts the next frame back-to-back with no idle cycle.
- mode=0, noise_seed=0x1234: two consecutive frames have bit-identical dat.
  - With noise_seed=0 the two frames differ.
- Deassert enable mid-frame: fv/lv/dat=0 next cycle, frame_count unchanged.
  - Re-enable restarts at row 0/col 0.
  - Asserting reset_n low asynchronously mid-line clears all outputs immediately.
- num_active_cols=0: fv toggles per frame, lv never asserts, dat stays 0.
  - total_cols=0 does not hang the counters.
